// File: rtl/psu_seq_pkg.sv
// rtl/psu_seq_pkg.sv - state encodings, default constants and width helper for the PSU rail sequencer
package psu_seq_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RAMP     = 3'd1;
  localparam logic [2:0] ST_RUN      = 3'd2;
  localparam logic [2:0] ST_SHUTDOWN = 3'd3;
  localparam logic [2:0] ST_FAULT    = 3'd4;

  localparam int DEF_NUM_CH     = 5;
  localparam int DEF_CNT_W      = 32;
  localparam int DEF_STEP_DLY   = 400;
  localparam int DEF_PG_TIMEOUT = 4000;
  localparam int DEF_PG_FILT    = 4;

  // A single rail still needs a 1-bit index port.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/psu_pg_filter.sv
// rtl/psu_pg_filter.sv - one rail of power-good synchroniser plus stable-count filter
module psu_pg_filter
  import psu_seq_pkg::*;
#(
  parameter int PG_FILT = DEF_PG_FILT
) (
  input  logic clk,
  input  logic n_rst,
  input  logic pg_i,
  output logic pg_o
);

  localparam int FW = $clog2(PG_FILT + 1);

  logic [1:0]    sync_q;
  logic [FW-1:0] cnt_q;
  logic          filt_q;

  // Output flips only after PG_FILT consecutive samples disagree with it.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pg_i};
      if (sync_q[1] == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == FW'(PG_FILT - 1)) begin
        filt_q <= sync_q[1];
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign pg_o = filt_q;

endmodule

// File: rtl/psu_sequencer.sv
// rtl/psu_sequencer.sv - N-rail power-up/power-down sequencer; PSU_SEQ_PG_FILTER_EN adds per-rail pg filtering
module psu_sequencer
  import psu_seq_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int STEP_DLY   = DEF_STEP_DLY,
  parameter int PG_TIMEOUT = DEF_PG_TIMEOUT,
  parameter int PG_FILT    = DEF_PG_FILT
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic                            en,
  input  logic                            clr_fault,
  input  logic [NUM_CH-1:0]               pg,
  output logic [NUM_CH-1:0]               act_ctl,
  output logic                            seq_done,
  output logic                            busy,
  output logic                            fault,
  output logic [clog2_min1(NUM_CH)-1:0]   fault_ch,
  output logic                            fault_to
);

  localparam int               CH_W      = clog2_min1(NUM_CH);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_DLY - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(PG_TIMEOUT - 1);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH - 1);

  logic [2:0]        state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0] act_q, act_d;
  logic [CH_W-1:0]   fch_q, fch_d;
  logic              fto_q, fto_d;
  logic [NUM_CH-1:0] pg_s;

`ifdef PSU_SEQ_PG_FILTER_EN
  for (genvar k = 0; k < NUM_CH; k++) begin : g_filt
    psu_pg_filter #(.PG_FILT(PG_FILT)) u_filt (
      .clk  (clk),
      .n_rst(n_rst),
      .pg_i (pg[k]),
      .pg_o (pg_s[k])
    );
  end
`else
  assign pg_s = pg;
`endif

  logic [NUM_CH-1:0] mon_mask;
  logic              loss, timeout, step_ok;
  logic [CH_W-1:0]   loss_ch, top_ch;

  // Rails already proven good are watched; the rail being ramped is not yet.
  always_comb begin
    mon_mask = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if ((state_q == ST_RUN) || ((state_q == ST_RAMP) && (CH_W'(k) < ch_q))) begin
        mon_mask[k] = 1'b1;
      end
    end
    loss    = |(~pg_s & mon_mask);
    loss_ch = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (!pg_s[k] && mon_mask[k]) loss_ch = CH_W'(k);
    end
    top_ch = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (act_q[k]) top_ch = CH_W'(k);
    end
    timeout = (state_q == ST_RAMP) && !pg_s[ch_q] && (cnt_q == TO_LAST);
    step_ok = (cnt_q >= STEP_LAST);
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    fch_d   = fch_q;
    fto_d   = fto_q;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d  = ST_RAMP;
          ch_d     = '0;
          cnt_d    = '0;
          act_d    = '0;
          act_d[0] = 1'b1;
        end
      end
      ST_RAMP, ST_RUN: begin
        if (timeout || loss) begin
          state_d = ST_FAULT;
          act_d   = '0;
          fch_d   = loss ? loss_ch : ch_q;
          fto_d   = !loss;
        end else if (!en) begin
          state_d       = ST_SHUTDOWN;
          act_d[top_ch] = 1'b0;
          ch_d          = top_ch;
          cnt_d         = '0;
        end else if (state_q == ST_RAMP) begin
          if (pg_s[ch_q] && step_ok) begin
            if (ch_q != CH_LAST) begin
              ch_d                 = ch_q + 1'b1;
              cnt_d                = '0;
              act_d[ch_q + 1'b1]   = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end else if (cnt_q != TO_LAST) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_SHUTDOWN: begin
        if (step_ok) begin
          cnt_d = '0;
          if (ch_q != '0) begin
            act_d[ch_q - 1'b1] = 1'b0;
            ch_d               = ch_q - 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FAULT: begin
        act_d = '0;
        if (clr_fault && !en) begin
          state_d = ST_IDLE;
          ch_d    = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ch_d    = '0;
        cnt_d   = '0;
        act_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      cnt_q   <= '0;
      act_q   <= '0;
      fch_q   <= '0;
      fto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      fch_q   <= fch_d;
      fto_q   <= fto_d;
    end
  end

  assign act_ctl  = act_q;
  assign seq_done = (state_q == ST_RUN);
  assign busy     = (state_q == ST_RAMP) || (state_q == ST_SHUTDOWN);
  assign fault    = (state_q == ST_FAULT);
  assign fault_ch = fch_q;
  assign fault_to = fto_q;

endmodule

// File: tb/tb_psu_sequencer.sv
// tb/tb_psu_sequencer.sv - directed self-checking bench for psu_sequencer (3 rails, step 4, timeout 16)
module tb_psu_sequencer;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       en;
  logic       clr_fault;
  logic [2:0] pg;
  logic [2:0] act_ctl;
  logic       seq_done;
  logic       busy;
  logic       fault;
  logic [1:0] fault_ch;
  logic       fault_to;

  int checks = 0;
  int errors = 0;

  psu_sequencer #(
    .NUM_CH(3), .CNT_W(8), .STEP_DLY(4), .PG_TIMEOUT(16), .PG_FILT(4)
  ) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .en       (en),
    .clr_fault(clr_fault),
    .pg       (pg),
    .act_ctl  (act_ctl),
    .seq_done (seq_done),
    .busy     (busy),
    .fault    (fault),
    .fault_ch (fault_ch),
    .fault_to (fault_to)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    n_rst = 1'b0; en = 1'b0; clr_fault = 1'b0; pg = 3'b000;
    tick(2);
    checks++; if ({act_ctl, seq_done, busy, fault, fault_ch, fault_to} !== 9'b0) begin
      errors++; $display("FAIL reset_outputs got=%b exp=%b", {act_ctl, seq_done, busy, fault, fault_ch, fault_to}, 9'b0); end
    n_rst = 1'b1;
    tick(1);
    checks++; if ({act_ctl, busy} !== 4'b0) begin
      errors++; $display("FAIL idle_hold got=%b exp=%b", {act_ctl, busy}, 4'b0); end
  endtask

  task automatic test_clean_ramp;
    en = 1'b1;
    tick(1);
    checks++; if (act_ctl !== 3'b001 || busy !== 1'b1) begin
      errors++; $display("FAIL ramp_start act=%b busy=%b exp act=001 busy=1", act_ctl, busy); end
    tick(2); pg = 3'b001;
    tick(1);
    checks++; if (act_ctl !== 3'b001) begin
      errors++; $display("FAIL ramp_step0_early act=%b exp=001", act_ctl); end
    tick(1);
    checks++; if (act_ctl !== 3'b011) begin
      errors++; $display("FAIL ramp_step1 act=%b exp=011", act_ctl); end
    tick(2); pg = 3'b011;
    tick(2);
    checks++; if (act_ctl !== 3'b111) begin
      errors++; $display("FAIL ramp_step2 act=%b exp=111", act_ctl); end
    tick(2); pg = 3'b111;
    tick(1);
    checks++; if (seq_done !== 1'b0) begin
      errors++; $display("FAIL run_early seq_done=%b exp=0", seq_done); end
    tick(1);
    checks++; if (seq_done !== 1'b1 || busy !== 1'b0 || fault !== 1'b0) begin
      errors++; $display("FAIL run_entry done=%b busy=%b fault=%b exp 1 0 0", seq_done, busy, fault); end
  endtask

  task automatic test_shutdown;
    en = 1'b0;
    tick(1);
    checks++; if (act_ctl !== 3'b011 || busy !== 1'b1 || seq_done !== 1'b0) begin
      errors++; $display("FAIL sd_first act=%b busy=%b done=%b exp 011 1 0", act_ctl, busy, seq_done); end
    tick(1); en = 1'b1;
    tick(1); en = 1'b0;
    tick(1);
    checks++; if (act_ctl !== 3'b011) begin
      errors++; $display("FAIL sd_hold act=%b exp=011", act_ctl); end
    tick(1);
    checks++; if (act_ctl !== 3'b001) begin
      errors++; $display("FAIL sd_step1 act=%b exp=001", act_ctl); end
    tick(4);
    checks++; if (act_ctl !== 3'b000 || busy !== 1'b1) begin
      errors++; $display("FAIL sd_step2 act=%b busy=%b exp 000 1", act_ctl, busy); end
    tick(3);
    checks++; if (busy !== 1'b1) begin
      errors++; $display("FAIL sd_last_wait busy=%b exp=1", busy); end
    tick(1);
    checks++; if (busy !== 1'b0 || act_ctl !== 3'b000 || fault !== 1'b0 || seq_done !== 1'b0) begin
      errors++; $display("FAIL sd_idle busy=%b act=%b fault=%b done=%b exp 0 000 0 0", busy, act_ctl, fault, seq_done); end
    pg = 3'b000;
    tick(2);
    checks++; if (act_ctl !== 3'b000 || busy !== 1'b0) begin
      errors++; $display("FAIL sd_stays_idle act=%b busy=%b exp 000 0", act_ctl, busy); end
  endtask

  task automatic test_slow_pg;
    en = 1'b1;
    tick(1);
    tick(2); pg = 3'b001;
    tick(2);
    checks++; if (act_ctl !== 3'b011) begin
      errors++; $display("FAIL slow_rail1_on act=%b exp=011", act_ctl); end
    tick(10);
    checks++; if (act_ctl !== 3'b011 || fault !== 1'b0) begin
      errors++; $display("FAIL slow_wait act=%b fault=%b exp 011 0", act_ctl, fault); end
    pg = 3'b011;
    tick(1);
    checks++; if (act_ctl !== 3'b111 || fault !== 1'b0) begin
      errors++; $display("FAIL slow_advance act=%b fault=%b exp 111 0", act_ctl, fault); end
    tick(2); pg = 3'b111;
    tick(2);
    checks++; if (seq_done !== 1'b1) begin
      errors++; $display("FAIL slow_run seq_done=%b exp=1", seq_done); end
  endtask

  task automatic test_run_loss;
    pg = 3'b010;
    tick(1);
    checks++; if (fault !== 1'b1 || act_ctl !== 3'b000 || fault_ch !== 2'd0 || fault_to !== 1'b0 || seq_done !== 1'b0) begin
      errors++; $display("FAIL run_loss fault=%b act=%b ch=%0d to=%b done=%b exp 1 000 0 0 0", fault, act_ctl, fault_ch, fault_to, seq_done); end
    en = 1'b0; clr_fault = 1'b1;
    tick(1);
    clr_fault = 1'b0; pg = 3'b000;
    checks++; if (fault !== 1'b0 || busy !== 1'b0 || act_ctl !== 3'b000) begin
      errors++; $display("FAIL run_loss_clear fault=%b busy=%b act=%b exp 0 0 000", fault, busy, act_ctl); end
  endtask

  task automatic test_timeout;
    en = 1'b1;
    tick(1);
    tick(2); pg = 3'b001;
    tick(2);
    tick(2); pg = 3'b011;
    tick(2);
    checks++; if (act_ctl !== 3'b111) begin
      errors++; $display("FAIL to_rail2_on act=%b exp=111", act_ctl); end
    tick(15);
    checks++; if (fault !== 1'b0 || act_ctl !== 3'b111) begin
      errors++; $display("FAIL to_early fault=%b act=%b exp 0 111", fault, act_ctl); end
    tick(1);
    checks++; if (fault !== 1'b1 || act_ctl !== 3'b000 || fault_ch !== 2'd2 || fault_to !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL to_fault fault=%b act=%b ch=%0d to=%b busy=%b exp 1 000 2 1 0", fault, act_ctl, fault_ch, fault_to, busy); end
    clr_fault = 1'b1;
    tick(1);
    clr_fault = 1'b0;
    checks++; if (fault !== 1'b1 || fault_ch !== 2'd2 || fault_to !== 1'b1 || act_ctl !== 3'b000) begin
      errors++; $display("FAIL to_clr_en_high fault=%b ch=%0d to=%b act=%b exp 1 2 1 000", fault, fault_ch, fault_to, act_ctl); end
    tick(1);
    en = 1'b0; clr_fault = 1'b1;
    tick(1);
    clr_fault = 1'b0; pg = 3'b000;
    checks++; if (fault !== 1'b0 || busy !== 1'b0 || act_ctl !== 3'b000) begin
      errors++; $display("FAIL to_clear fault=%b busy=%b act=%b exp 0 0 000", fault, busy, act_ctl); end
  endtask

  task automatic test_reset_mid_ramp;
    en = 1'b1;
    tick(1);
    tick(2); pg = 3'b001;
    tick(2);
    checks++; if (act_ctl !== 3'b011) begin
      errors++; $display("FAIL rst_pre act=%b exp=011", act_ctl); end
    n_rst = 1'b0;
    #1;
    checks++; if (act_ctl !== 3'b000 || busy !== 1'b0 || fault !== 1'b0) begin
      errors++; $display("FAIL rst_async act=%b busy=%b fault=%b exp 000 0 0", act_ctl, busy, fault); end
    pg = 3'b000;
    tick(2);
    n_rst = 1'b1;
    tick(1);
    checks++; if (act_ctl !== 3'b001 || busy !== 1'b1) begin
      errors++; $display("FAIL rst_restart act=%b busy=%b exp 001 1", act_ctl, busy); end
    tick(3);
    checks++; if (act_ctl !== 3'b001) begin
      errors++; $display("FAIL rst_restart_hold act=%b exp=001", act_ctl); end
  endtask

  initial begin
    test_reset;
    test_clean_ramp;
    test_shutdown;
    test_slow_pg;
    test_run_loss;
    test_timeout;
    test_reset_mid_ramp;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
